dtm_dmi_master: RTL
===================

DTM_DMI_MASTER -- requirements
Module: dtm_dmi_master

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low, on ports sys_clk (clock) and sys_rstn (reset).
REQ-002 Parameters, one per line (name, default, meaning):
- ABITS, 7, DMI address width.
- TIMEOUT, 255, maximum number of WAIT cycles before abort; legal range 1..255.
REQ-003 Ports, one per line (name  direction  width  meaning):
- sys_clk  in  1  clock.
- sys_rstn  in  1  sync active-low reset.
- dmi_cmd_valid  in  1  host command strobe, single-cycle.
- dmi_cmd_op  in  2  0 nop, 1 read, 2 write, 3 reserved.
- dmi_cmd_addr  in  ABITS  DM register address.
- dmi_cmd_data  in  32  write data.
- dmi_reset  in  1  pulse; clears sticky status.
- dmi_hard_reset  in  1  pulse; abort outstanding access and clear status.
- dmi_busy  out  1  access in progress.
- dmi_stat  out  2  sticky status: 0 ok, 2 failed, 3 busy.
- dmi_rdata  out  32  last successful read data.
- dtm_req_valid  out  1  DMI request valid.
- dtm_req_ready  in  1  DM accepts request.
- dtm_req_bits  out  `DBUS_M_WIDTH (ABITS+34)  {addr, data[31:0], op[1:0]}.
- dm_resp_valid  in  1  DM response valid.
- dm_resp_ready  out  1  master accepts response.
- dm_resp_bits  in  `DBUS_S_WIDTH (34)  {data[31:0], resp[1:0]}.

Function
REQ-004 The state machine SHALL have four states:
- IDLE: waiting for a command.
- REQ: dtm_req_valid=1.
- WAIT: dm_resp_ready=1, timeout counter running.
- DRAIN: dm_resp_ready=1, the next response is discarded.
REQ-005 The block SHALL output dmi_busy = (state != IDLE).
REQ-006 A command SHALL be accepted only when all of the following hold in the same cycle: dmi_cmd_valid=1, state IDLE, dmi_stat=0 (after any same-cycle dmi_reset), and op 1 or 2. On acceptance the block SHALL capture addr/data/op into dtm_req_bits and enter REQ at the next cycle.
REQ-007 Ops 0 and 3 SHALL be ignored without any status change.
REQ-008 When dmi_cmd_valid=1 while state != IDLE, dmi_stat SHALL become 3 if it is currently 0. The command SHALL be dropped.
REQ-009 When dmi_cmd_valid=1 in IDLE with dmi_stat != 0, the command SHALL be dropped and the status left unchanged.
REQ-010 In REQ, dtm_req_valid and dtm_req_bits SHALL be held stable until dtm_req_ready=1. The block SHALL then enter WAIT and clear the timeout counter. The valid/ready handshake SHALL never be withdrawn.
REQ-011 In WAIT, dm_resp_valid=1 SHALL complete the access and return the block to IDLE at the next cycle, with status per resp:
- resp 0: dmi_rdata updated from the response data (read only; unchanged for write).
- resp 2 or 1: dmi_stat=2.
- resp 3: dmi_stat=3.
REQ-012 The timeout counter SHALL be 8 bits and increment each WAIT cycle without a response. At count==TIMEOUT-1 with no response, the next state SHALL be DRAIN and dmi_stat=2. A response arriving in that same cycle SHALL win; no timeout occurs.
REQ-013 In DRAIN, the first dm_resp_valid SHALL be consumed and discarded, then the block SHALL return to IDLE. DRAIN has no timeout.
REQ-014 dmi_reset SHALL clear dmi_stat only; it SHALL NOT affect the state.
REQ-015 dmi_hard_reset SHALL clear dmi_stat and act per state:
- IDLE: no further effect.
- WAIT: go to DRAIN.
- REQ: keep valid until accept, then go to DRAIN.
- DRAIN: stay in DRAIN.
REQ-016 dmi_stat update precedence, highest first: hard_reset, dmi_reset, response/timeout error, busy collision. An error from an error source SHALL be written only when dmi_stat is 0 after higher-precedence clears, except that response/timeout errors SHALL always overwrite a busy (3) value set in the same cycle.
REQ-017 Latency:
- Command accept at cycle N: dtm_req_valid=1 at N+1.
- Response at cycle M: dmi_busy=0 and dmi_rdata/dmi_stat valid at M+1.
- Minimum read round trip: 3 cycles.

Reset
REQ-018 With sys_rstn=0 at a clock edge, the block SHALL enter IDLE and set dtm_req_valid=0, dtm_req_bits=0, dm_resp_ready=0, dmi_busy=0, dmi_stat=0, dmi_rdata=0, counter=0. This SHALL apply mid-transaction, with no draining.
REQ-019 While in reset, all inputs SHALL be ignored.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Read addr 0x11, DM ready immediately, resp {0xDEADBEEF,0} one cycle later -> dtm_req_bits={0x11,0,1}; dmi_rdata=0xDEADBEEF, dmi_stat=0, busy low 3 cycles after the command.
- Write addr 0x04 data 0x1, dtm_req_ready held low 5 cycles -> valid/bits stable all 5 cycles; on completion dmi_rdata unchanged, dmi_stat=0.
- Second command during WAIT -> dmi_stat=3; the subsequent command is dropped until dmi_reset; after dmi_reset, a read is accepted normally.
- TIMEOUT=4, no response -> dmi_stat=2 after 4 WAIT cycles; state DRAIN with busy=1; a later response is discarded (dmi_rdata unchanged); then IDLE.
- Resp code 3, then dmi_hard_reset during WAIT of the next attempt -> dmi_stat=3, then 0; block goes to DRAIN and recovers to IDLE after the response.
- sys_rstn asserted in REQ -> next cycle all outputs take their REQ-018 reset values; an immediate read is accepted normally.

Source files
------------

// File: rtl/dtm_dmi_master.sv
// DMI master for a debug transport module: issues one host read/write at a time to the
// debug module, tracks a sticky status, and recovers from timeouts and aborts by draining.
module dtm_dmi_master #(
    parameter int unsigned ABITS   = 7,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             sys_clk,
    input  logic             sys_rstn,
    input  logic             dmi_cmd_valid,
    input  logic [1:0]       dmi_cmd_op,
    input  logic [ABITS-1:0] dmi_cmd_addr,
    input  logic [31:0]      dmi_cmd_data,
    input  logic             dmi_reset,
    input  logic             dmi_hard_reset,
    output logic             dmi_busy,
    output logic [1:0]       dmi_stat,
    output logic [31:0]      dmi_rdata,
    output logic             dtm_req_valid,
    input  logic             dtm_req_ready,
    output logic [ABITS+33:0] dtm_req_bits,
    input  logic             dm_resp_valid,
    output logic             dm_resp_ready,
    input  logic [33:0]      dm_resp_bits
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] ST_OK    = 2'd0;
    localparam logic [1:0] ST_FAIL  = 2'd2;
    localparam logic [1:0] ST_BUSY  = 2'd3;

    // One-hot so every output decode is a single flop bit.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_REQ   = 4'b0010,
        S_WAIT  = 4'b0100,
        S_DRAIN = 4'b1000
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             abort_pending;
    logic [1:0]       stat_clr;
    logic [1:0]       stat_next;
    logic             accept;
    logic             wait_done;
    logic             timeout_hit;
    logic             collision;
    logic [1:0]       resp_code;
    logic [31:0]      resp_data;

    assign resp_code = dm_resp_bits[1:0];
    assign resp_data = dm_resp_bits[33:2];

    // Status after the same-cycle clears; gates acceptance and error writes.
    assign stat_clr    = (dmi_hard_reset || dmi_reset) ? ST_OK : dmi_stat;
    assign accept      = dmi_cmd_valid && (state == S_IDLE) && (stat_clr == ST_OK) &&
                         ((dmi_cmd_op == OP_READ) || (dmi_cmd_op == OP_WRITE));
    assign wait_done   = (state == S_WAIT) && dm_resp_valid && !dmi_hard_reset;
    assign timeout_hit = (state == S_WAIT) && !dm_resp_valid && !dmi_hard_reset &&
                         (cnt == CNT_LAST);
    assign collision   = dmi_cmd_valid && (state != S_IDLE);

    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_REQ;
            S_REQ:   if (dtm_req_ready) state_next = (abort_pending || dmi_hard_reset) ? S_DRAIN : S_WAIT;
            // A response arriving with a hard reset is still consumed, just not reported.
            S_WAIT:  if (dm_resp_valid) state_next = S_IDLE;
                     else if (dmi_hard_reset || timeout_hit) state_next = S_DRAIN;
            S_DRAIN: if (dm_resp_valid) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        dmi_busy      = (state != S_IDLE);
        dtm_req_valid = (state == S_REQ);
        dm_resp_ready = (state == S_WAIT) || (state == S_DRAIN);
    end

    // Error sources test the pre-collision value, so they overwrite a same-cycle busy.
    always_comb begin
        stat_next = stat_clr;
        if (stat_clr == ST_OK) begin
            if (timeout_hit) begin
                stat_next = ST_FAIL;
            end else if (wait_done && (resp_code != 2'd0)) begin
                stat_next = (resp_code == 2'd3) ? ST_BUSY : ST_FAIL;
            end else if (collision) begin
                stat_next = ST_BUSY;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rstn) begin
            cnt           <= '0;
            abort_pending <= 1'b0;
            dtm_req_bits  <= '0;
            dmi_stat      <= ST_OK;
            dmi_rdata     <= '0;
        end else begin
            dmi_stat      <= stat_next;
            abort_pending <= (state == S_REQ) && !dtm_req_ready && (abort_pending || dmi_hard_reset);
            if (accept) begin
                dtm_req_bits <= {dmi_cmd_addr, dmi_cmd_data, dmi_cmd_op};
            end
            if ((state == S_REQ) && dtm_req_ready) begin
                cnt <= '0;
            end else if ((state == S_WAIT) && !dm_resp_valid) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (wait_done && (resp_code == 2'd0) && (dtm_req_bits[1:0] == OP_READ)) begin
                dmi_rdata <= resp_data;
            end
        end
    end

endmodule
